aurora_nfc_flow_ctrl: RTL

Parametrised Aurora native-flow-control (NFC) generator for the receive side of an Aurora link. It watches the fill levels of up to `NumChannels` downstream receive buffers. It issues XOFF/XON NFC requests with programmable hysteresis, and in timed mode it re-issues XOFF periodically so a timed pause never expires while a buffer is congested. It sits between the receive-side width-scaling buffers and the Aurora core NFC port, in the `userclk` domain.

---
 rtl/aurora_pkg.sv | 16 +
 rtl/nfc_level_aggregator.sv | 34 +++
 rtl/aurora_nfc_flow_ctrl.sv | 93 +++++++++
 3 files changed

// File: rtl/aurora_pkg.sv
// aurora_pkg: shared NFC state encoding, default NFC payloads and request/response structs.
package aurora_pkg;
    typedef enum logic [1:0] {OPEN, XOFF_SEND, HELD, XON_SEND} nfc_state_e;
    localparam logic [15:0] XOFF_CODE = 16'h0010;
    localparam logic [15:0] XON_CODE  = 16'h0000;
    typedef struct packed {
        logic [15:0] data;
    } axis_nfc_t;
    typedef struct packed {
        logic      tvalid;
        axis_nfc_t t;
    } axis_nfc_req_t;
    typedef struct packed {
        logic tready;
    } axis_nfc_resp_t;
endpackage

// File: rtl/nfc_level_aggregator.sv
// nfc_level_aggregator: registers per-channel levels/enables and folds them into one
// congestion flag with XOFF/XON hysteresis.
module nfc_level_aggregator #(
    parameter int NumChannels = 1,
    parameter int LevelWidth  = 5,
    parameter int XoffLevel   = 8,
    parameter int XonLevel    = 4
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [NumChannels-1:0]            chan_en,
    input  logic [NumChannels*LevelWidth-1:0] fill_level,
    output logic                              congested
);
    logic [NumChannels-1:0]            en_q;
    logic [NumChannels*LevelWidth-1:0] level_q;
    logic [NumChannels-1:0]            hi, lo;
    for (genvar i = 0; i < NumChannels; i++) begin : g_ch
        assign hi[i] = en_q[i] && level_q[i*LevelWidth +: LevelWidth] >= LevelWidth'(XoffLevel);
        assign lo[i] = !en_q[i] || level_q[i*LevelWidth +: LevelWidth] <= LevelWidth'(XonLevel);
    end
    // With nothing enabled, lo is all ones and hi is zero, so the flag clears.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_q      <= '0;
            level_q   <= '0;
            congested <= 1'b0;
        end else begin
            en_q      <= chan_en;
            level_q   <= fill_level;
            congested <= |hi ? 1'b1 : &lo ? 1'b0 : congested;
        end
    end
endmodule

// File: rtl/aurora_nfc_flow_ctrl.sv
// aurora_nfc_flow_ctrl: issues Aurora NFC XOFF/XON frames from downstream buffer
// congestion, optionally refreshing XOFF periodically while the partner is paused.
module aurora_nfc_flow_ctrl
    import aurora_pkg::*;
#(
    parameter int          NumChannels   = 1,
    parameter int          LevelWidth    = 5,
    parameter int          XoffLevel     = 8,
    parameter int          XonLevel      = 4,
    parameter logic [15:0] XoffCode      = XOFF_CODE,
    parameter logic [15:0] XonCode       = XON_CODE,
    parameter int          RefreshCycles = 0,
    parameter int          CountWidth    = 16
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              channel_up,
    input  logic [NumChannels-1:0]            chan_en,
    input  logic [NumChannels*LevelWidth-1:0] fill_level,
    output axis_nfc_req_t                     nfc_req,
    input  axis_nfc_resp_t                    nfc_resp,
    output logic                              congested,
    output logic                              xoff_active,
    output logic [CountWidth-1:0]             xoff_count
);
    localparam int RefW = RefreshCycles > 1 ? $clog2(RefreshCycles) : 1;
    localparam logic [RefW-1:0] RefLoad = RefreshCycles > 0 ? RefW'(RefreshCycles - 1) : '0;
    nfc_state_e      state_q, state_d;
    logic            act_d;
    logic [CountWidth-1:0] cnt_d;
    logic [RefW-1:0] ref_q, ref_d;
    nfc_level_aggregator #(
        .NumChannels(NumChannels),
        .LevelWidth (LevelWidth),
        .XoffLevel  (XoffLevel),
        .XonLevel   (XonLevel)
    ) u_agg (
        .clk       (clk),
        .reset_n   (reset_n),
        .chan_en   (chan_en),
        .fill_level(fill_level),
        .congested (congested)
    );
    always_comb begin
        state_d = state_q;
        act_d   = xoff_active;
        cnt_d   = xoff_count;
        ref_d   = ref_q;
        if (!channel_up) begin
            state_d = OPEN;
            act_d   = 1'b0;
            ref_d   = '0;
        end else begin
            case (state_q)
                OPEN:      if (congested) state_d = XOFF_SEND;
                XOFF_SEND: if (nfc_resp.tready) begin
                    state_d = HELD;
                    act_d   = 1'b1;
                    ref_d   = RefLoad;
                    cnt_d   = &xoff_count ? xoff_count : xoff_count + 1'b1;
                end
                HELD: begin
                    if (!congested) state_d = XON_SEND;
                    else if (RefreshCycles > 0 && ref_q == '0) state_d = XOFF_SEND;
                    else if (ref_q != '0) ref_d = ref_q - 1'b1;
                end
                XON_SEND: if (nfc_resp.tready) begin
                    state_d = OPEN;
                    act_d   = 1'b0;
                end
                default: state_d = OPEN;
            endcase
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= OPEN;
            xoff_active <= 1'b0;
            xoff_count  <= '0;
            ref_q       <= '0;
        end else begin
            state_q     <= state_d;
            xoff_active <= act_d;
            xoff_count  <= cnt_d;
            ref_q       <= ref_d;
        end
    end
    // Request is a pure decode of the state register, so it cannot glitch on tready.
    always_comb begin
        nfc_req.tvalid = state_q == XOFF_SEND || state_q == XON_SEND;
        nfc_req.t.data = state_q == XOFF_SEND ? XoffCode : state_q == XON_SEND ? XonCode : '0;
    end
endmodule
